// File: rtl/cipher_seq_ctrl.sv
// cipher_seq_ctrl
// Sequencer for the cipher datapath. Captures one block and key, starts
// key expansion (with a timeout), then steps the round datapath through
// NUM_ROUNDS rounds in encrypt (ascending) or decrypt (descending) order.
// Optional key-wrap: after an operation, re-runs the rounds on the session
// key under the master key. Enabled by defining CSC_KEY_WRAP_EN; otherwise
// key_op/mk_key are ignored and key_done stays 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_op, ed_sel    start request and mode (1 = encrypt), sampled in IDLE
//   key_op              key-wrap request, sampled in DONE
//   key_expanded        key schedule ready (level)
//   r_ready             round datapath ready (level)
//   data_in, key_in     block and session key
//   mk_key              master key used by the wrap phase
//   e_data, e_key       registered block/key presented downstream
//   dec_mode            1 while a decrypt operation is active
//   start_key_exp       1-cycle pulse starting key expansion
//   round_en, round_idx round strobe and current round index
//   busy                high whenever not IDLE
//   en_done, key_done   completion pulses (key_done only on wrap phase)
//   err                 1-cycle pulse on key-expansion timeout
module cipher_seq_ctrl #(
  parameter int DATA_W      = 128,
  parameter int KEY_W       = 128,
  parameter int NUM_ROUNDS  = 10,
  parameter int EXP_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_op,
  input  logic              ed_sel,
  input  logic              key_op,
  input  logic              key_expanded,
  input  logic              r_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [KEY_W-1:0]  key_in,
  input  logic [KEY_W-1:0]  mk_key,
  output logic [DATA_W-1:0] e_data,
  output logic [KEY_W-1:0]  e_key,
  output logic              dec_mode,
  output logic              start_key_exp,
  output logic              round_en,
  output logic [7:0]        round_idx,
  output logic              busy,
  output logic              en_done,
  output logic              key_done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KEY_EXP, S_WAIT_RDY, S_ROUND, S_DONE, S_KW_LOAD, S_ERR
  } state_t;

  localparam logic [15:0] TIMEOUT    = 16'(EXP_TIMEOUT);
  localparam logic [7:0]  LAST_ROUND = 8'(NUM_ROUNDS - 1);

  state_t      state;
  logic [15:0] exp_cnt;
  logic [7:0]  round_cnt;
  logic        wrap;       // current phase is a key-wrap phase
  logic        wrap_req;

`ifdef CSC_KEY_WRAP_EN
  // Only one wrap phase per operation: a wrap DONE never chains again.
  assign wrap_req = key_op & ~wrap;
`else
  assign wrap_req = 1'b0;
  logic unused_wrap_inputs;
  assign unused_wrap_inputs = ^{key_op, mk_key};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      exp_cnt       <= '0;
      round_cnt     <= '0;
      wrap          <= 1'b0;
      e_data        <= '0;
      e_key         <= '0;
      dec_mode      <= 1'b0;
      start_key_exp <= 1'b0;
      round_en      <= 1'b0;
      round_idx     <= '0;
      busy          <= 1'b0;
      en_done       <= 1'b0;
      key_done      <= 1'b0;
      err           <= 1'b0;
    end else begin
      // Pulse outputs default low; set only on the transition into a state.
      start_key_exp <= 1'b0;
      en_done       <= 1'b0;
      key_done      <= 1'b0;
      err           <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_op) begin
            dec_mode <= ~ed_sel;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          e_data        <= data_in;
          e_key         <= key_in;
          exp_cnt       <= '0;
          start_key_exp <= 1'b1;
          state         <= S_KEY_EXP;
        end

        S_KEY_EXP: begin
          // key_expanded takes priority over a timeout in the same cycle.
          if (key_expanded) begin
            state <= S_WAIT_RDY;
          end else if (exp_cnt == TIMEOUT) begin
            err      <= 1'b1;
            e_data   <= '0;
            e_key    <= '0;
            dec_mode <= 1'b0;
            state    <= S_ERR;
          end else begin
            exp_cnt <= exp_cnt + 16'd1;
          end
        end

        S_WAIT_RDY: begin
          if (r_ready) begin
            round_en  <= 1'b1;
            round_cnt <= '0;
            round_idx <= dec_mode ? LAST_ROUND : 8'd0;
            state     <= S_ROUND;
          end
        end

        S_ROUND: begin
          if (round_cnt == LAST_ROUND) begin
            round_en  <= 1'b0;
            round_idx <= '0;
            en_done   <= 1'b1;
            key_done  <= wrap;
            state     <= S_DONE;
          end else begin
            round_cnt <= round_cnt + 8'd1;
            round_idx <= dec_mode ? round_idx - 8'd1 : round_idx + 8'd1;
          end
        end

        S_DONE: begin
          if (wrap_req) begin
            state <= S_KW_LOAD;
          end else begin
            wrap  <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

`ifdef CSC_KEY_WRAP_EN
        S_KW_LOAD: begin
          e_data        <= DATA_W'(key_in);
          e_key         <= mk_key;
          dec_mode      <= 1'b0;
          wrap          <= 1'b1;
          exp_cnt       <= '0;
          start_key_exp <= 1'b1;
          state         <= S_KEY_EXP;
        end
`endif

        S_ERR: begin
          wrap  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          wrap  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_seq_ctrl.sv
// Testbench for cipher_seq_ctrl. Stimulus pushes expected events (start pulse,
// rounds, done, error) with their expected cycle into a scoreboard; a monitor
// pops and compares whenever the DUT presents one of those outputs.
module tb_cipher_seq_ctrl;
  localparam int DW = 64;
  localparam int KW = 32;
  localparam int NR = 10;
  localparam int TO = 8;

  logic          clk, rst, start_op, ed_sel, key_op, key_expanded, r_ready;
  logic [DW-1:0] data_in;
  logic [KW-1:0] key_in, mk_key;
  logic [DW-1:0] e_data;
  logic [KW-1:0] e_key;
  logic          dec_mode, start_key_exp, round_en, busy, en_done, key_done, err;
  logic [7:0]    round_idx;

  cipher_seq_ctrl #(.DATA_W(DW), .KEY_W(KW), .NUM_ROUNDS(NR), .EXP_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start_op(start_op), .ed_sel(ed_sel), .key_op(key_op),
    .key_expanded(key_expanded), .r_ready(r_ready), .data_in(data_in),
    .key_in(key_in), .mk_key(mk_key), .e_data(e_data), .e_key(e_key),
    .dec_mode(dec_mode), .start_key_exp(start_key_exp), .round_en(round_en),
    .round_idx(round_idx), .busy(busy), .en_done(en_done), .key_done(key_done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef enum int {EV_SKE = 0, EV_RND = 1, EV_DONE = 2, EV_ERR = 3} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    int            cyc;
    int            idx;
    bit            dec;
    bit            kd;
    logic [DW-1:0] edata;
    logic [KW-1:0] ekey;
  } ev_t;
  ev_t sb[$];

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_ev(ev_kind_t k, int c, int idx, bit dec, bit kd,
                                  logic [DW-1:0] d, logic [KW-1:0] key);
    ev_t e;
    e.kind = k; e.cyc = c; e.idx = idx; e.dec = dec; e.kd = kd; e.edata = d; e.ekey = key;
    sb.push_back(e);
  endfunction

  // Cycle n of an operation is cyc == e0 + n (start_op sampled at the end of cycle 0).
  function automatic void push_op(int e0, bit dec, logic [DW-1:0] d, logic [KW-1:0] key,
                                  bit kd, int rdelay, int nrounds, bit with_done);
    push_ev(EV_SKE, e0 + 2, 0, dec, 0, d, key);
    for (int i = 0; i < nrounds; i++)
      push_ev(EV_RND, e0 + 4 + rdelay + i, dec ? NR - 1 - i : i, dec, 0, d, key);
    if (with_done)
      push_ev(EV_DONE, e0 + 4 + rdelay + NR, 0, dec, kd, d, key);
  endfunction

  // Monitor / scoreboard checker
  always @(negedge clk) begin
    ev_t      e;
    int       n;
    ev_kind_t act;
    n = int'(start_key_exp) + int'(round_en) + int'(en_done) + int'(err);
    if (!rst && key_done && !en_done) begin
      checks++; errors++;
      $display("FAIL key_done_alone: got 1 expected 0 (cyc %0d)", cyc);
    end
    if (n > 1) begin
      checks++; errors++;
      $display("FAIL overlap: got %0d event outputs expected 1 (cyc %0d)", n, cyc);
    end else if (n == 1) begin
      act = err ? EV_ERR : en_done ? EV_DONE : round_en ? EV_RND : EV_SKE;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event: got kind %0d expected none (cyc %0d)", int'(act), cyc);
      end else begin
        e = sb.pop_front();
        chk("event_kind", int'(act), int'(e.kind));
        chk("event_cycle", cyc, e.cyc);
        if (act == e.kind) begin
          case (e.kind)
            EV_SKE: begin
              chk("ske_e_data", e_data, e.edata);
              chk("ske_e_key", e_key, e.ekey);
              chk("ske_dec_mode", dec_mode, e.dec);
            end
            EV_RND: begin
              chk("round_idx", round_idx, e.idx);
              chk("round_dec_mode", dec_mode, e.dec);
              chk("round_busy", busy, 1);
            end
            EV_DONE: begin
              chk("done_key_done", key_done, e.kd);
              chk("done_e_data", e_data, e.edata);
              chk("done_e_key", e_key, e.ekey);
              chk("done_dec_mode", dec_mode, e.dec);
              chk("done_busy", busy, 1);
              chk("done_round_idx", round_idx, 0);
              $display("txn done cyc=%0d dec=%0d key_done=%0d e_data=%0h e_key=%0h",
                       cyc, dec_mode, key_done, e_data, e_key);
            end
            default: begin
              chk("err_busy", busy, 1);
              $display("txn err cyc=%0d", cyc);
            end
          endcase
        end
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_e_data"}, e_data, 0);
    chk({tag, "_e_key"}, e_key, 0);
    chk({tag, "_outs"}, {dec_mode, start_key_exp, round_en, busy, en_done, key_done, err}, 0);
    chk({tag, "_round_idx"}, round_idx, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  localparam logic [DW-1:0] D1 = 64'h0123_4567_89ab_cdef;
  localparam logic [KW-1:0] K1 = 32'hdead_beef;
  localparam logic [KW-1:0] MK = 32'h0bad_f00d;

  initial begin
    int e0, e0b;
    logic [DW-1:0] zx;
    rst = 1'b1; start_op = 1'b0; ed_sel = 1'b1; key_op = 1'b0;
    key_expanded = 1'b1; r_ready = 1'b1; data_in = D1; key_in = K1; mk_key = MK;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: nominal encrypt
    ed_sel = 1'b1; start_op = 1'b1; e0 = cyc;
    push_op(e0, 0, D1, K1, 0, 0, NR, 1);
    @(negedge clk); start_op = 1'b0;
    wait_cyc(e0 + NR + 5);
    chk("enc_busy_after", busy, 0);
    chk("enc_sb_drained", sb.size(), 0);

    // 2: nominal decrypt
    ed_sel = 1'b0; start_op = 1'b1; e0 = cyc;
    push_op(e0, 1, D1, K1, 0, 0, NR, 1);
    @(negedge clk); start_op = 1'b0;
    chk("dec_mode_load", dec_mode, 1);
    wait_cyc(e0 + NR + 5);
    chk("dec_busy_after", busy, 0);

    // 3: key-expansion timeout (decrypt so dec_mode clearing is visible)
    key_expanded = 1'b0; ed_sel = 1'b0; start_op = 1'b1; e0 = cyc;
    push_ev(EV_SKE, e0 + 2, 0, 1, 0, D1, K1);
    push_ev(EV_ERR, e0 + 3 + TO, 0, 0, 0, 0, 0);
    @(negedge clk); start_op = 1'b0;
    wait_cyc(e0 + 4 + TO);
    chk("to_busy", busy, 0);
    chk("to_e_data", e_data, 0);
    chk("to_e_key", e_key, 0);
    chk("to_dec_mode", dec_mode, 0);
    key_expanded = 1'b1;
    @(negedge clk);

    // 4: key-wrap request (decrypt first phase)
    key_op = 1'b1; ed_sel = 1'b0; start_op = 1'b1; e0 = cyc;
    zx = DW'(K1);
    push_op(e0, 1, D1, K1, 0, 0, NR, 1);
`ifdef CSC_KEY_WRAP_EN
    push_op(e0 + NR + 4, 0, zx, MK, 1, 0, NR, 1);
    e0b = e0 + 2 * NR + 9;
`else
    e0b = e0 + NR + 5;
`endif
    @(negedge clk); start_op = 1'b0;
    wait_cyc(e0b);
    chk("kw_busy_after", busy, 0);
    key_op = 1'b0;
    @(negedge clk);

    // 5: reset in round cycle 5, then a full nominal run
    ed_sel = 1'b1; start_op = 1'b1; e0 = cyc;
    push_op(e0, 0, D1, K1, 0, 0, 6, 0);
    @(negedge clk); start_op = 1'b0;
    wait_cyc(e0 + 9);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    data_in = 64'hfeed_face_cafe_0001; key_in = 32'h1357_9bdf;
    start_op = 1'b1; e0 = cyc;
    push_op(e0, 0, data_in, key_in, 0, 0, NR, 1);
    @(negedge clk); start_op = 1'b0;
    wait_cyc(e0 + NR + 5);
    chk("postrst_busy", busy, 0);

    // 6: r_ready low 3 cycles in WAIT_RDY, stray start_op during ROUND
    r_ready = 1'b0; start_op = 1'b1; e0 = cyc;
    push_op(e0, 0, data_in, key_in, 0, 3, NR, 1);
    @(negedge clk); start_op = 1'b0;
    wait_cyc(e0 + 6); r_ready = 1'b1;
    wait_cyc(e0 + 9); start_op = 1'b1;
    @(negedge clk); start_op = 1'b0;
    wait_cyc(e0 + NR + 8);
    chk("rdy_busy_after", busy, 0);
    repeat (4) @(negedge clk);
    chk("rdy_no_restart", busy, 0);

    // 7: back-to-back with start_op held high
    ed_sel = 1'b1; start_op = 1'b1; e0 = cyc;
    e0b = e0 + NR + 5;
    push_op(e0, 0, data_in, key_in, 0, 0, NR, 1);
    push_op(e0b, 0, data_in, key_in, 0, 0, NR, 1);
    wait_cyc(e0b + 1); start_op = 1'b0;
    wait_cyc(e0b + NR + 5);
    chk("b2b_busy_after", busy, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
